mmu_xlate: RTL
==============

# mmu_xlate

Parametrised single-outstanding translation front end for the MMU: accepts a VA/PCID request, looks it up in an internal fully-associative PCID-tagged TLB, and on a miss issues a page-walk request and fills the TLB from the response. It supersedes the fixed 64-bit, free-running lookup pipeline with a valid/ready request handshake, a walker interface, PCID/global flush and saturating hit/miss/fill counters. It sits between the core address path and the page walker / STLB.

## Interface
- VA_W, 64, virtual address width
- PA_W, 64, physical address width
- PCID_W, 12, process-context identifier width
- OFF_W, 12, page-offset width; VPN = VA_W-OFF_W bits, PPN = PA_W-OFF_W bits
- ENTRIES, 8, TLB entries (power of two, >=2)
- CNT_W, 32, statistics counter width

- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_va  in  VA_W  virtual address
- req_pcid  in  PCID_W  PCID
- resp_valid  out  1  one-cycle response strobe, no backpressure
- resp_pa  out  PA_W  translated address, held until next response
- resp_hit  out  1  response came from TLB hit
- resp_fault  out  1  walker reported fault; resp_pa = 0
- walk_valid  out  1  walk request, held until walk_done
- walk_vpn  out  VA_W-OFF_W  VPN to walk
- walk_pcid  out  PCID_W  PCID to walk
- walk_done  in  1  walk result valid (sampled only in WALK)
- walk_ppn  in  PA_W-OFF_W  resulting PPN
- walk_fault  in  1  translation fault
- flush_valid  in  1  flush command
- flush_all  in  1  1: invalidate all entries; 0: only entries with PCID == flush_pcid
- flush_pcid  in  PCID_W  PCID to flush
- stat_hit, stat_miss, stat_fill  out  CNT_W  saturating counters

## Operation
- States: IDLE, LOOKUP, WALK, FILL, RESP.
- IDLE: req_ready = !flush_valid. flush_valid has priority: in one cycle clears matching valid bits, stays IDLE. Otherwise on handshake capture va/pcid -> LOOKUP.
- flush_valid outside IDLE is ignored; caller holds it until req_ready would be high (IDLE).
- LOOKUP: compare captured {VPN, PCID} against all valid entries. Hit: resp_pa <= {ppn, va[OFF_W-1:0]}, resp_hit<=1, stat_hit++ -> RESP. Miss: stat_miss++ -> WALK.
- WALK: walk_valid=1 with captured vpn/pcid. On walk_done: fault -> resp_pa<=0, resp_fault<=1, resp_hit<=0, no fill -> RESP; else -> FILL.
- FILL: write entry {valid, vpn, pcid, walk_ppn} at victim, stat_fill++, resp_pa <= {walk_ppn, va offset}, resp_hit<=0 -> RESP.
- Victim: lowest-index invalid entry; if all valid, round-robin pointer rr, then rr <= rr+1 mod ENTRIES (wraps). rr untouched when an invalid entry is used.
- RESP: resp_valid=1 for exactly one cycle -> IDLE.
- walk_ppn latched at walk_done; later walk inputs ignored.
- Only one translation outstanding; no duplicate entries possible.
- Counters saturate at all-ones, never wrap.
- Reset: state IDLE, all valid bits 0, rr=0, counters 0, resp_valid/resp_hit/resp_fault/walk_valid=0, resp_pa=0. Reset mid-walk aborts: walk_valid drops next cycle, no fill, no response.

## Timing
- Handshake at edge N; LOOKUP cycle N+1; resp_valid in cycle N+2 on hit (2-cycle hit latency); req_ready high again N+3.
- Miss: walk_valid first high in cycle N+2; walk_done at edge M -> FILL cycle M+1, resp_valid cycle M+2. Fault: resp_valid cycle M+1.
- walk_done in the same cycle walk_valid first rises is legal.
- Fill visible to the next request's LOOKUP.
- Flush: accepted at edge F, entries invalid for any LOOKUP after F.

## Test plan
- Reset, req va=0x1234 pcid=0, walker returns ppn=0xABC after 3 cycles -> walk_vpn=0x1, resp_pa=0xABC234, resp_hit=0, stat_miss=1, stat_fill=1.
- Repeat va=0x1FFF pcid=0 -> resp_valid 2 cycles after handshake, resp_pa=0xABCFFF, resp_hit=1, no walk_valid, stat_hit=1.
- Same va with pcid=5 -> miss, walk; then flush_all=0 flush_pcid=0 -> pcid 0 entry misses again, pcid 5 entry still hits.
- Fill ENTRIES+2 distinct VPNs (0..9) -> entries 0 and 1 replaced by VPNs 8, 9 (rr wrap); VPN 0 misses, VPN 2 hits.
- walk_fault=1 on va=0x5000 -> resp_fault=1, resp_pa=0, stat_fill unchanged; re-request misses again.
- Assert rst during WALK -> walk_valid 0 next cycle, no resp_valid, all counters 0, prior hits now miss.

Source files
------------

// File: rtl/mmu_xlate.sv
// Single-outstanding VA->PA translation front end: fully-associative PCID-tagged TLB,
// page-walk request on miss, PCID/global flush and saturating hit/miss/fill counters.
module mmu_xlate #(
    parameter int unsigned VA_W    = 64,
    parameter int unsigned PA_W    = 64,
    parameter int unsigned PCID_W  = 12,
    parameter int unsigned OFF_W   = 12,
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [VA_W-1:0]         req_va,
    input  logic [PCID_W-1:0]       req_pcid,
    output logic                    resp_valid,
    output logic [PA_W-1:0]         resp_pa,
    output logic                    resp_hit,
    output logic                    resp_fault,
    output logic                    walk_valid,
    output logic [VA_W-OFF_W-1:0]   walk_vpn,
    output logic [PCID_W-1:0]       walk_pcid,
    input  logic                    walk_done,
    input  logic [PA_W-OFF_W-1:0]   walk_ppn,
    input  logic                    walk_fault,
    input  logic                    flush_valid,
    input  logic                    flush_all,
    input  logic [PCID_W-1:0]       flush_pcid,
    output logic [CNT_W-1:0]        stat_hit,
    output logic [CNT_W-1:0]        stat_miss,
    output logic [CNT_W-1:0]        stat_fill
);
    localparam int unsigned VPN_W = VA_W - OFF_W;
    localparam int unsigned PPN_W = PA_W - OFF_W;
    localparam int unsigned IDX_W = $clog2(ENTRIES);

    typedef enum logic [2:0] {StIdle, StLookup, StWalk, StFill, StResp} state_e;

    state_e              state_q, state_d;
    logic [VA_W-1:0]     va_q, va_d;
    logic [PCID_W-1:0]   pcid_q, pcid_d;
    logic [PPN_W-1:0]    walk_ppn_q, walk_ppn_d;
    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [VPN_W-1:0]    tag_vpn_q [ENTRIES];
    logic [VPN_W-1:0]    tag_vpn_d [ENTRIES];
    logic [PCID_W-1:0]   tag_pcid_q [ENTRIES];
    logic [PCID_W-1:0]   tag_pcid_d [ENTRIES];
    logic [PPN_W-1:0]    ppn_q [ENTRIES];
    logic [PPN_W-1:0]    ppn_d [ENTRIES];
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [PA_W-1:0]     resp_pa_q, resp_pa_d;
    logic                resp_hit_q, resp_hit_d;
    logic                resp_fault_q, resp_fault_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]    fill_cnt_q, fill_cnt_d;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             has_free;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] victim;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (valid_q[i] && tag_vpn_q[i] == va_q[VA_W-1:OFF_W] && tag_pcid_q[i] == pcid_q) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Lowest-index free slot wins; round-robin only once the TLB is full.
    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        victim = has_free ? free_idx : rr_q;
    end

    always_comb begin
        state_d      = state_q;
        va_d         = va_q;
        pcid_d       = pcid_q;
        walk_ppn_d   = walk_ppn_q;
        valid_d      = valid_q;
        tag_vpn_d    = tag_vpn_q;
        tag_pcid_d   = tag_pcid_q;
        ppn_d        = ppn_q;
        rr_d         = rr_q;
        resp_pa_d    = resp_pa_q;
        resp_hit_d   = resp_hit_q;
        resp_fault_d = resp_fault_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        fill_cnt_d   = fill_cnt_q;
        req_ready    = 1'b0;
        walk_valid   = 1'b0;
        resp_valid   = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = !flush_valid;
                if (flush_valid) begin
                    for (int i = 0; i < int'(ENTRIES); i++) begin
                        if (flush_all || tag_pcid_q[i] == flush_pcid) valid_d[i] = 1'b0;
                    end
                end else if (req_valid) begin
                    va_d    = req_va;
                    pcid_d  = req_pcid;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (hit) begin
                    resp_pa_d    = {ppn_q[hit_idx], va_q[OFF_W-1:0]};
                    resp_hit_d   = 1'b1;
                    resp_fault_d = 1'b0;
                    hit_cnt_d    = sat_inc(hit_cnt_q);
                    state_d      = StResp;
                end else begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    state_d    = StWalk;
                end
            end
            StWalk: begin
                walk_valid = 1'b1;
                if (walk_done) begin
                    walk_ppn_d = walk_ppn;
                    if (walk_fault) begin
                        resp_pa_d    = '0;
                        resp_hit_d   = 1'b0;
                        resp_fault_d = 1'b1;
                        state_d      = StResp;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                valid_d[victim]    = 1'b1;
                tag_vpn_d[victim]  = va_q[VA_W-1:OFF_W];
                tag_pcid_d[victim] = pcid_q;
                ppn_d[victim]      = walk_ppn_q;
                if (!has_free) rr_d = rr_q + IDX_W'(1);
                fill_cnt_d   = sat_inc(fill_cnt_q);
                resp_pa_d    = {walk_ppn_q, va_q[OFF_W-1:0]};
                resp_hit_d   = 1'b0;
                resp_fault_d = 1'b0;
                state_d      = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            va_q         <= '0;
            pcid_q       <= '0;
            walk_ppn_q   <= '0;
            valid_q      <= '0;
            rr_q         <= '0;
            resp_pa_q    <= '0;
            resp_hit_q   <= 1'b0;
            resp_fault_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            fill_cnt_q   <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_vpn_q[i]  <= '0;
                tag_pcid_q[i] <= '0;
                ppn_q[i]      <= '0;
            end
        end else begin
            state_q      <= state_d;
            va_q         <= va_d;
            pcid_q       <= pcid_d;
            walk_ppn_q   <= walk_ppn_d;
            valid_q      <= valid_d;
            rr_q         <= rr_d;
            resp_pa_q    <= resp_pa_d;
            resp_hit_q   <= resp_hit_d;
            resp_fault_q <= resp_fault_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            fill_cnt_q   <= fill_cnt_d;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_vpn_q[i]  <= tag_vpn_d[i];
                tag_pcid_q[i] <= tag_pcid_d[i];
                ppn_q[i]      <= ppn_d[i];
            end
        end
    end

    assign resp_pa    = resp_pa_q;
    assign resp_hit   = resp_hit_q;
    assign resp_fault = resp_fault_q;
    assign walk_vpn   = va_q[VA_W-1:OFF_W];
    assign walk_pcid  = pcid_q;
    assign stat_hit   = hit_cnt_q;
    assign stat_miss  = miss_cnt_q;
    assign stat_fill  = fill_cnt_q;

endmodule
